// File: rtl/id_issue_queue_if.sv
// Handshake and datapath bundle for the decode/issue queue: upstream IPD
// push side, register-file read port, bypass network and EXE issue side.
interface id_issue_queue_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned NUM_BYP   = 3,
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned CNT_W     = 32
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic                      in_valid;
  logic                      in_allow_in;
  logic [NUM_SRC-1:0]        in_src_sel;
  logic [NUM_SRC*5-1:0]      in_src_addr;
  logic [NUM_SRC*XLEN-1:0]   in_imm;
  logic [PAYLOAD_W-1:0]      in_payload;
  logic [NUM_SRC*5-1:0]      rf_r_addr;
  logic [NUM_SRC*XLEN-1:0]   rf_r_data;
  logic [NUM_BYP-1:0]        byp_valid;
  logic [NUM_BYP-1:0]        byp_w_en;
  logic [NUM_BYP-1:0]        byp_data_valid;
  logic [NUM_BYP*5-1:0]      byp_addr;
  logic [NUM_BYP*XLEN-1:0]   byp_data;
  logic                      flush;
  logic                      out_valid;
  logic                      out_allow_in;
  logic [NUM_SRC*XLEN-1:0]   out_src;
  logic [PAYLOAD_W-1:0]      out_payload;
  logic [OCC_W-1:0]          occupancy;
  logic [CNT_W-1:0]          stall_cycles;

  // Surrounding pipeline (IPD, register file, bypass stages, EXE)
  modport master (
    output in_valid, in_src_sel, in_src_addr, in_imm, in_payload,
    output rf_r_data, byp_valid, byp_w_en, byp_data_valid, byp_addr, byp_data,
    output flush, out_allow_in,
    input  in_allow_in, rf_r_addr, out_valid, out_src, out_payload,
    input  occupancy, stall_cycles
  );

  // The issue queue itself
  modport slave (
    input  in_valid, in_src_sel, in_src_addr, in_imm, in_payload,
    input  rf_r_data, byp_valid, byp_w_en, byp_data_valid, byp_addr, byp_data,
    input  flush, out_allow_in,
    output in_allow_in, rf_r_addr, out_valid, out_src, out_payload,
    output occupancy, stall_cycles
  );
endinterface

// File: rtl/id_issue_queue.sv
// In-order decode/issue queue. Holds decoded instructions in a circular
// buffer, resolves the head entry's source operands from immediates, the
// prioritised bypass ports or the register file, and issues when all ready.
module id_issue_queue #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned NUM_BYP   = 3,
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  id_issue_queue_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  // Entry storage: never reset, validity is tracked by count_q
  logic [NUM_SRC-1:0]      sel_q  [DEPTH];
  logic [NUM_SRC*5-1:0]    addr_q [DEPTH];
  logic [NUM_SRC*XLEN-1:0] imm_q  [DEPTH];
  logic [PAYLOAD_W-1:0]    pay_q  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic                    not_empty, all_ready, push, pop, stall_now, hit;
  logic [4:0]              src_a;
  logic [NUM_SRC*XLEN-1:0] src_val;

  assign not_empty = (count_q != '0);

  // Resolve head operands; the first matching bypass port wins even if its data is not ready
  always_comb begin
    src_val   = '0;
    all_ready = 1'b1;
    src_a     = '0;
    hit       = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_a = addr_q[head_q][i*5 +: 5];
      hit   = 1'b0;
      if (!sel_q[head_q][i]) begin
        src_val[i*XLEN +: XLEN] = imm_q[head_q][i*XLEN +: XLEN];
      end else if (src_a != '0) begin
        for (int unsigned k = 0; k < NUM_BYP; k++) begin
          if (!hit && bus.byp_valid[k] && bus.byp_w_en[k] &&
              (bus.byp_addr[k*5 +: 5] == src_a)) begin
            hit = 1'b1;
            if (bus.byp_data_valid[k]) src_val[i*XLEN +: XLEN] = bus.byp_data[k*XLEN +: XLEN];
            else                       all_ready = 1'b0;
          end
        end
        if (!hit) src_val[i*XLEN +: XLEN] = bus.rf_r_data[i*XLEN +: XLEN];
      end
    end
  end

  assign bus.out_valid    = not_empty & all_ready & ~bus.flush;
  assign bus.out_src      = bus.out_valid ? src_val : '0;
  assign bus.out_payload  = bus.out_valid ? pay_q[head_q] : '0;
  assign bus.rf_r_addr    = not_empty ? addr_q[head_q] : '0;
  assign bus.in_allow_in  = (count_q < FULL_CNT) | pop;
  assign bus.occupancy    = count_q;
  assign bus.stall_cycles = stall_q;

  assign pop       = bus.out_valid & bus.out_allow_in;
  assign push      = bus.in_valid & bus.in_allow_in & ~bus.flush;
  assign stall_now = not_empty & ~all_ready & ~bus.flush;

  // Pointer, occupancy and stall-counter next state; flush overrides push/pop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    stall_d = stall_q;
    if (stall_now && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + OCC_W'(1);
      else if (pop && !push) count_d = count_q - OCC_W'(1);
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Capture the incoming instruction at the tail slot
  always_ff @(posedge clk) begin
    if (push) begin
      sel_q[tail_q]  <= bus.in_src_sel;
      addr_q[tail_q] <= bus.in_src_addr;
      imm_q[tail_q]  <= bus.in_imm;
      pay_q[tail_q]  <= bus.in_payload;
    end
  end
endmodule

// File: tb/tb_id_issue_queue.sv
// Self-checking bench for id_issue_queue: directed scenarios plus a random
// phase, all compared against a queue-based reference model.
module tb_id_issue_queue;
  localparam int unsigned XLEN = 32, DEPTH = 4, NSRC = 2, NBYP = 3, PW = 64, CW = 32;

  logic clk, reset;
  int unsigned total, bad;
  logic [31:0] rf [32];

  typedef struct {
    logic [NSRC-1:0]      sel;
    logic [NSRC*5-1:0]    addr;
    logic [NSRC*XLEN-1:0] imm;
    logic [PW-1:0]        pay;
  } ent_t;

  ent_t        q[$];
  logic [CW-1:0] stall_m;

  id_issue_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_SRC(NSRC), .NUM_BYP(NBYP),
                      .PAYLOAD_W(PW), .CNT_W(CW)) bus ();

  id_issue_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_SRC(NSRC), .NUM_BYP(NBYP),
                   .PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model answering the DUT's read addresses combinationally
  always_comb begin
    bus.rf_r_data = '0;
    for (int i = 0; i < NSRC; i++)
      bus.rf_r_data[i*XLEN +: XLEN] = rf[bus.rf_r_addr[i*5 +: 5]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_src_sel = '0; bus.in_src_addr = '0; bus.in_imm = '0;
    bus.in_payload = '0; bus.byp_valid = '0; bus.byp_w_en = '0; bus.byp_data_valid = '0;
    bus.byp_addr = '0; bus.byp_data = '0; bus.flush = 0; bus.out_allow_in = 0;
  endtask

  task automatic set_byp(input int k, input logic [4:0] a, input logic dv, input logic [31:0] d);
    bus.byp_valid[k] = 1; bus.byp_w_en[k] = 1; bus.byp_data_valid[k] = dv;
    bus.byp_addr[k*5 +: 5] = a; bus.byp_data[k*XLEN +: XLEN] = d;
  endtask

  task automatic push_in(input logic [1:0] sel, input logic [4:0] a1, input logic [4:0] a0,
                         input logic [63:0] imm, input logic [63:0] pay);
    bus.in_valid = 1; bus.in_src_sel = sel; bus.in_src_addr = {a1, a0};
    bus.in_imm = imm; bus.in_payload = pay;
  endtask

  // Check all outputs against the model for this cycle, then advance one edge
  task automatic step();
    ent_t e;
    logic rdy, r, ov, allow, push, pop, sinc;
    logic [63:0] val, pay;
    logic [9:0] ra;
    logic [4:0] a;
    logic [31:0] v;
    int m;
    #1;
    rdy = 1; val = '0; pay = '0; ra = '0;
    if (q.size() != 0) begin
      ra = q[0].addr; pay = q[0].pay;
      for (int i = 0; i < NSRC; i++) begin
        a = q[0].addr[i*5 +: 5]; r = 1; v = '0;
        if (!q[0].sel[i]) v = q[0].imm[i*XLEN +: XLEN];
        else if (a != 0) begin
          m = -1;
          for (int k = 0; k < NBYP; k++)
            if (m < 0 && bus.byp_valid[k] && bus.byp_w_en[k] && bus.byp_addr[k*5 +: 5] == a) m = k;
          if (m < 0) v = rf[a];
          else if (bus.byp_data_valid[m]) v = bus.byp_data[m*XLEN +: XLEN];
          else r = 0;
        end
        val[i*XLEN +: XLEN] = v;
        rdy = rdy & r;
      end
    end
    ov    = (q.size() != 0) && rdy && !bus.flush;
    allow = (q.size() < DEPTH) || (ov && bus.out_allow_in);
    check("out_valid", 64'(bus.out_valid), 64'(ov));
    check("in_allow_in", 64'(bus.in_allow_in), 64'(allow));
    check("out_src", bus.out_src, ov ? val : 64'd0);
    check("out_payload", bus.out_payload, ov ? pay : 64'd0);
    check("rf_r_addr", 64'(bus.rf_r_addr), 64'(ra));
    check("occupancy", 64'(bus.occupancy), 64'(q.size()));
    check("stall_cycles", 64'(bus.stall_cycles), 64'(stall_m));
    push = bus.in_valid && allow && !bus.flush;
    pop  = ov && bus.out_allow_in;
    sinc = (q.size() != 0) && !rdy && !bus.flush;
    e.sel = bus.in_src_sel; e.addr = bus.in_src_addr; e.imm = bus.in_imm; e.pay = bus.in_payload;
    @(posedge clk);
    if (bus.flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    if (sinc && stall_m != '1) stall_m++;
    #1;
  endtask

  initial begin
    total = 0; bad = 0; stall_m = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[1] = 32'd5; rf[2] = 32'd7;
    idle();
    reset = 1;
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_allow_in", 64'(bus.in_allow_in), 64'd1);
    check("rst_occupancy", 64'(bus.occupancy), 64'd0);
    check("rst_stall", 64'(bus.stall_cycles), 64'd0);
    reset = 0;
    @(posedge clk); #1;

    // ADD r1, r2 from the register file
    push_in(2'b11, 5'd2, 5'd1, 64'd0, 64'hADD);
    #1 check("add_pre_valid", 64'(bus.out_valid), 64'd0);
    step();
    idle();
    #1 check("add_src", bus.out_src, {32'd7, 32'd5});
    step();
    bus.out_allow_in = 1;
    step();
    idle();

    // r3 waits on an EXE result that is not yet available
    push_in(2'b01, 5'd0, 5'd3, {32'h99, 32'h0}, 64'h33);
    step();
    idle();
    set_byp(0, 5'd3, 0, 32'hDEAD);
    bus.out_allow_in = 1;
    step();
    step();
    set_byp(0, 5'd3, 1, 32'h1234);
    #1 check("stall_src0", 64'(bus.out_src[31:0]), 64'h1234);
    check("stall_cnt", 64'(bus.stall_cycles), 64'd2);
    step();
    idle();

    // Youngest bypass wins; r0 ignores bypass
    push_in(2'b11, 5'd0, 5'd4, 64'd0, 64'h44);
    step();
    idle();
    set_byp(0, 5'd4, 1, 32'hAAAA);
    set_byp(2, 5'd4, 1, 32'hBBBB);
    set_byp(1, 5'd0, 1, 32'hCCCC);
    bus.out_allow_in = 1;
    #1 check("prio_src", bus.out_src, {32'd0, 32'hAAAA});
    step();
    idle();

    // Fill to DEPTH, then push+pop while full, then drain across wrap
    for (int n = 0; n < DEPTH; n++) begin
      push_in(2'b00, 5'd0, 5'd0, {32'(n), 32'(n + 100)}, 64'(n + 16'h100));
      step();
    end
    #1 check("full_allow", 64'(bus.in_allow_in), 64'd0);
    check("full_occ", 64'(bus.occupancy), 64'd4);
    step();
    push_in(2'b00, 5'd0, 5'd0, 64'h55, 64'h1FF);
    bus.out_allow_in = 1;
    step();
    idle();
    #1 check("pp_occ", 64'(bus.occupancy), 64'd4);
    bus.out_allow_in = 1;
    for (int n = 0; n < DEPTH + 1; n++) step();
    idle();

    // Flush with three entries and a simultaneous input
    for (int n = 0; n < 3; n++) begin
      push_in(2'b00, 5'd0, 5'd0, 64'(n), 64'(n + 16'h200));
      step();
    end
    push_in(2'b00, 5'd0, 5'd0, 64'hF, 64'h2FF);
    bus.flush = 1;
    bus.out_allow_in = 1;
    #1 check("flush_valid", 64'(bus.out_valid), 64'd0);
    step();
    idle();
    #1 check("flush_occ", 64'(bus.occupancy), 64'd0);
    check("flush_allow", 64'(bus.in_allow_in), 64'd1);
    bus.out_allow_in = 1;
    step();
    step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      bus.in_valid = ($urandom_range(3) != 0);
      bus.in_src_sel = 2'($urandom);
      for (int i = 0; i < NSRC; i++) bus.in_src_addr[i*5 +: 5] = 5'($urandom_range(7));
      bus.in_imm = {$urandom, $urandom};
      bus.in_payload = {$urandom, $urandom};
      bus.byp_valid = 3'($urandom);
      bus.byp_w_en = 3'($urandom);
      bus.byp_data_valid = 3'($urandom);
      for (int k = 0; k < NBYP; k++) begin
        bus.byp_addr[k*5 +: 5] = 5'($urandom_range(7));
        bus.byp_data[k*XLEN +: XLEN] = $urandom;
      end
      bus.flush = ($urandom_range(15) == 0);
      bus.out_allow_in = ($urandom_range(3) != 0);
      step();
    end
    idle();
    bus.flush = 1;
    step();
    idle();

    // Asynchronous reset while two entries stall on r5
    push_in(2'b01, 5'd0, 5'd5, 64'd0, 64'h501);
    step();
    push_in(2'b01, 5'd0, 5'd5, 64'd0, 64'h502);
    set_byp(0, 5'd5, 0, 32'h0);
    step();
    bus.in_valid = 0;
    bus.out_allow_in = 1;
    step();
    step();
    #2 reset = 1;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_occ", 64'(bus.occupancy), 64'd0);
    check("arst_stall", 64'(bus.stall_cycles), 64'd0);
    q.delete();
    stall_m = '0;
    #2 reset = 0;
    idle();
    @(posedge clk); #1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_issue_queue.md
Name: id_issue_queue

Overview:
- Parametrised successor to the decode/issue stage.
- Buffers decoded instructions in an in-order circular queue of DEPTH entries between IPD and EXE.
- Resolves NUM_SRC register operands per head entry. Each operand comes from NUM_BYP prioritised bypass ports or the register file.
- Issues the head instruction to EXE only when all its operands are ready. Supports branch-mispredict flush, and provides stall accounting and occupancy outputs.

Parameters:
XLEN, 32, datapath/operand width
DEPTH, 4, queue entries (power of two, >=2)
NUM_SRC, 2, source operands per instruction
NUM_BYP, 3, bypass ports; index 0 = youngest producer (EXE), highest priority
PAYLOAD_W, 64, opaque decoded-control payload carried alongside operands
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream instruction valid
in_allow_in  out  1  queue can accept this cycle
in_src_sel  in  NUM_SRC  per operand: 1 = register, 0 = immediate
in_src_addr  in  NUM_SRC*5  source register numbers
in_imm  in  NUM_SRC*XLEN  immediate value per operand
in_payload  in  PAYLOAD_W  decoded control bundle
rf_r_addr  out  NUM_SRC*5  register-file read addresses (head entry)
rf_r_data  in  NUM_SRC*XLEN  combinational register-file read data
byp_valid  in  NUM_BYP  stage holds a valid instruction
byp_w_en  in  NUM_BYP  stage instruction writes a register
byp_data_valid  in  NUM_BYP  stage result already available
byp_addr  in  NUM_BYP*5  stage destination register
byp_data  in  NUM_BYP*XLEN  stage result
flush  in  1  branch mispredict cancel
out_valid  out  1  head instruction issuable
out_allow_in  in  1  EXE accepts
out_src  out  NUM_SRC*XLEN  resolved operands
out_payload  out  PAYLOAD_W  head payload
occupancy  out  clog2(DEPTH+1)  entries held
stall_cycles  out  CNT_W  cumulative operand-stall cycles

Behaviour:
- Reset (asynchronous): head/tail pointers = 0, count = 0, stall_cycles = 0.
  - out_valid = 0, in_allow_in = 1, occupancy = 0.
  - Entry storage is not cleared.
- push = in_valid & in_allow_in & ~flush.
- pop = out_valid & out_allow_in.
- in_allow_in = (count < DEPTH) | pop. Push and pop in the same cycle are allowed when full; count is unchanged.
- Latency: an instruction pushed into an empty queue at edge t is at the head and may issue in cycle t+1. There is no same-cycle fall-through.
- Pointers wrap modulo DEPTH. count is never above DEPTH and never below 0.
- rf_r_addr is driven from the head entry's src_addr at all times. It is 0 when empty.
- Operand resolution for head operand i (combinational):
  - sel = 0: value = imm, ready.
  - sel = 1 and addr = 0: value = 0, ready; bypass is ignored.
  - Otherwise take the lowest k with byp_valid[k] & byp_w_en[k] & byp_addr[k] == addr:
    - If byp_data_valid[k]: value = byp_data[k], ready.
    - Else: not ready, value = 0.
    - Older ports are never consulted past the first match.
  - No match: value = rf_r_data[i], ready.
- out_valid = (count != 0) & all operands ready & ~flush.
- out_src and out_payload are valid only when out_valid = 1. When out_valid = 0 they are driven to 0.
- flush: at the next edge all entries are discarded (head = tail = 0, count = 0).
  - An in_valid presented in the flush cycle is dropped.
  - No issue occurs in the flush cycle.
  - flush has priority over push and pop.
- stall_cycles increments by 1 on each edge where count != 0, operands are not all ready, and flush = 0. It saturates at all-ones and is cleared only by reset.
- occupancy = count (registered).
- Reset asserted mid-operation immediately empties the queue and drops out_valid asynchronously.

Test Plan:
- Reset then push ADD (src regs r1 = 5, r2 = 7 from RF, no bypass match) -> out_valid rises the cycle after the push; out_src = {7, 5}; stall_cycles stays 0.
- Head needs r3; byp[0] matches r3 with data_valid = 0 for 2 cycles, then 1 with data 0x1234 -> out_valid low for 2 cycles, then out_src[0] = 0x1234; stall_cycles = 2.
- r4 matches both byp[0] (data 0xAAAA) and byp[2] (data 0xBBBB), both data_valid -> out_src = 0xAAAA. Source r0 with a matching bypass -> 0.
- out_allow_in = 0 while pushing DEPTH = 4 instructions -> in_allow_in = 0 after 4 pushes, occupancy = 4. Then pulse out_allow_in with in_valid = 1 -> simultaneous pop and push, occupancy stays 4. Issue order equals push order across pointer wrap.
- Queue holds 3 entries and flush is asserted with in_valid = 1 -> out_valid = 0 that cycle; next cycle occupancy = 0, in_allow_in = 1; the flushed input never issues.
- Assert reset asynchronously mid-stall with 2 entries queued -> out_valid, occupancy and stall_cycles go to 0 without waiting for a clk edge.
